// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives a negedge-read instruction ROM from the PC register and
// hands {instr, pc} downstream one word per cycle, with start/halt control and branch flush.
module inst_fetch #(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       DATA_WIDTH    = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter logic [DATA_WIDTH-1:0]    HALT_WORD     = '1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sink_start,
    input  logic                     sink_branch_en,
    input  logic [ADDRESS_WIDTH-1:0] sink_branch_target,
    output logic [ADDRESS_WIDTH-1:0] rom_address,
    output logic                     rom_ren,
    output logic                     rom_cen,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    output logic [DATA_WIDTH-1:0]    src_instr,
    output logic [ADDRESS_WIDTH-1:0] src_pc,
    output logic                     src_valid,
    input  logic                     src_ready,
    output logic                     src_halted,
    output logic [1:0]               o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0]    r_instr;
    logic [DATA_WIDTH-1:0]    w_instr_nxt;
    logic [ADDRESS_WIDTH-1:0] r_src_pc;
    logic [ADDRESS_WIDTH-1:0] w_src_pc_nxt;
    logic                     r_valid;
    logic                     w_valid_nxt;
    logic                     r_halted;
    logic                     w_halted_nxt;
    logic                     w_accept;

    // Output handshake: a word transfers on any posedge where src_valid && src_ready;
    // src_instr/src_pc stay stable while src_valid && !src_ready (except a FETCH-state branch flush).
    assign w_accept = !r_valid || src_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_src_pc <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_src_pc <= w_src_pc_nxt;
            r_valid  <= w_valid_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_src_pc_nxt = r_src_pc;
        w_valid_nxt  = r_valid;
        w_halted_nxt = r_halted;
        case (r_state)
            S_FETCH: begin
                // Branch wins: the ROM word for the old PC is wrong-path and is dropped.
                if (sink_branch_en) begin
                    w_pc_nxt    = sink_branch_target;
                    w_valid_nxt = 1'b0;
                end else if (w_accept) begin
                    w_instr_nxt  = rom_data;
                    w_src_pc_nxt = r_pc;
                    w_valid_nxt  = 1'b1;
                    w_pc_nxt     = r_pc + ADDRESS_WIDTH'(1);
                    if (rom_data == HALT_WORD) begin
                        w_state_nxt  = S_HALT;
                        w_halted_nxt = 1'b1;
                    end
                end
            end
            S_IDLE, S_HALT: begin
                // A held word still drains here; a branch only retargets the PC.
                if (src_ready) begin
                    w_valid_nxt = 1'b0;
                end
                if (sink_branch_en) begin
                    w_pc_nxt = sink_branch_target;
                end
                if (sink_start) begin
                    w_state_nxt  = S_FETCH;
                    w_halted_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rom_address = r_pc;
    assign rom_cen     = (r_state == S_FETCH);
    assign rom_ren     = (r_state == S_FETCH);
    assign src_instr   = r_instr;
    assign src_pc      = r_src_pc;
    assign src_valid   = r_valid;
    assign src_halted  = r_halted;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized stream checked against a
// transaction-level model of which address each delivered word must come from.
module tb_inst_fetch;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          sink_start;
    logic          sink_branch_en;
    logic [AW-1:0] sink_branch_target;
    logic [AW-1:0] rom_address;
    logic          rom_ren;
    logic          rom_cen;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] src_instr;
    logic [AW-1:0] src_pc;
    logic          src_valid;
    logic          src_ready;
    logic          src_halted;
    logic [1:0]    dbg_state;

    logic          sink_start2;
    logic [AW-1:0] rom_address2;
    logic          rom_ren2;
    logic          rom_cen2;
    logic [DW-1:0] rom_data2;
    logic [DW-1:0] src_instr2;
    logic [AW-1:0] src_pc2;
    logic          src_valid2;
    logic          src_halted2;
    logic [1:0]    dbg_state2;

    logic [DW-1:0] mem [0:65535];
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] exp_pc;
    int            n_checks;
    int            n_errors;
    int            hs_count;

    inst_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(16'h0000), .HALT_WORD(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .sink_start(sink_start), .sink_branch_en(sink_branch_en),
        .sink_branch_target(sink_branch_target), .rom_address(rom_address), .rom_ren(rom_ren),
        .rom_cen(rom_cen), .rom_data(rom_data), .src_instr(src_instr), .src_pc(src_pc),
        .src_valid(src_valid), .src_ready(src_ready), .src_halted(src_halted),
        .o_dbg_state(dbg_state)
    );

    inst_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(16'hFFFE), .HALT_WORD(16'hFFFF)) dut2 (
        .clk(clk), .rst(rst), .sink_start(sink_start2), .sink_branch_en(1'b0),
        .sink_branch_target(16'h0000), .rom_address(rom_address2), .rom_ren(rom_ren2),
        .rom_cen(rom_cen2), .rom_data(rom_data2), .src_instr(src_instr2), .src_pc(src_pc2),
        .src_valid(src_valid2), .src_ready(1'b1), .src_halted(src_halted2),
        .o_dbg_state(dbg_state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ROM models: sample the address on negedge when enabled.
    always @(negedge clk) begin
        if (rom_cen && rom_ren) rom_data <= mem[rom_address];
        if (rom_cen2 && rom_ren2) rom_data2 <= mem[rom_address2];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sink_start     = 1'b0;
        sink_branch_en = 1'b0;
        rst            = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_pulse();
        sink_start = 1'b1;
        tick();
        sink_start = 1'b0;
    endtask

    // Scoreboard: each handshake must carry the next program-order address, which
    // advances by one per delivered word and jumps to any branch target.
    initial begin
        exp_pc   = 16'h0000;
        hs_count = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc = 16'h0000;
            end else begin
                if (src_valid && src_ready) begin
                    check("hs_pc", 32'(src_pc), 32'(exp_pc));
                    check("hs_instr", 32'(src_instr), 32'(mem[exp_pc]));
                    exp_pc = exp_pc + 16'h1;
                    hs_count++;
                end
                if (sink_branch_en) exp_pc = sink_branch_target;
            end
        end
    end

    initial begin
        int found;
        int hs_before;
        logic [AW-1:0] e;
        n_checks           = 0;
        n_errors           = 0;
        rst                = 1'b1;
        sink_start         = 1'b0;
        sink_start2        = 1'b0;
        sink_branch_en     = 1'b0;
        sink_branch_target = '0;
        src_ready          = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
        for (int i = 0; i < 4; i++) mem[i] = 16'(16'h00A0 + i);

        // reset state
        do_reset();
        check("rst_valid", 32'(src_valid), 0);
        check("rst_instr", 32'(src_instr), 0);
        check("rst_pc", 32'(src_pc), 0);
        check("rst_halted", 32'(src_halted), 0);
        check("rst_cen", 32'(rom_cen), 0);
        check("rst_ren", 32'(rom_ren), 0);
        check("rst_addr", 32'(rom_address), 0);
        check("rst_state", 32'(dbg_state), 0);

        // straight-line fetch of 0..3
        src_ready = 1'b1;
        start_pulse();
        check("t1_state", 32'(dbg_state), 1);
        check("t1_cen", 32'(rom_cen), 1);
        check("t1_first_nv", 32'(src_valid), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_valid", 32'(src_valid), 1);
            check("t1_pc", 32'(src_pc), 32'(i));
            check("t1_instr", 32'(src_instr), 32'(16'h00A0 + i));
        end

        // backpressure while word 1 is presented
        do_reset();
        start_pulse();
        tick();
        tick();
        check("t2_pc1", 32'(src_pc), 1);
        src_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_valid", 32'(src_valid), 1);
            check("t2_hold_pc", 32'(src_pc), 1);
            check("t2_hold_instr", 32'(src_instr), 32'(16'h00A1));
            check("t2_hold_addr", 32'(rom_address), 2);
        end
        src_ready = 1'b1;
        tick();
        check("t2_pc2", 32'(src_pc), 2);
        check("t2_instr2", 32'(src_instr), 32'(16'h00A2));
        tick();
        check("t2_pc3", 32'(src_pc), 3);

        // branch flushes a held word
        do_reset();
        start_pulse();
        tick();
        src_ready = 1'b0;
        tick();
        check("t3_held", 32'(src_valid), 1);
        sink_branch_en     = 1'b1;
        sink_branch_target = 16'h0040;
        tick();
        sink_branch_en = 1'b0;
        src_ready      = 1'b1;
        check("t3_flush", 32'(src_valid), 0);
        check("t3_addr", 32'(rom_address), 32'(16'h0040));
        tick();
        check("t3_valid", 32'(src_valid), 1);
        check("t3_pc", 32'(src_pc), 32'(16'h0040));
        check("t3_instr", 32'(src_instr), 32'(mem[16'h0040]));
        tick();
        check("t3_pc_next", 32'(src_pc), 32'(16'h0041));

        // halt word at address 5, then resume
        mem[5] = 16'hFFFF;
        do_reset();
        start_pulse();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (src_valid && src_pc == 16'h0005) found = 1;
        end
        check("t4_reached", 32'(found), 1);
        check("t4_instr", 32'(src_instr), 32'(16'hFFFF));
        check("t4_halted", 32'(src_halted), 1);
        check("t4_cen", 32'(rom_cen), 0);
        check("t4_addr", 32'(rom_address), 6);
        check("t4_state", 32'(dbg_state), 2);
        tick();
        check("t4_drained", 32'(src_valid), 0);
        tick();
        check("t4_idle", 32'(src_valid), 0);
        start_pulse();
        check("t4_unhalt", 32'(src_halted), 0);
        check("t4_resume_state", 32'(dbg_state), 1);
        tick();
        check("t4_resume_pc", 32'(src_pc), 6);
        check("t4_resume_valid", 32'(src_valid), 1);
        tick();
        mem[5] = 16'h0005;

        // asynchronous reset mid-stream, then start together with a branch
        do_reset();
        start_pulse();
        repeat (3) tick();
        check("t6_pre_valid", 32'(src_valid), 1);
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(src_valid), 0);
        check("t6_addr", 32'(rom_address), 0);
        check("t6_state", 32'(dbg_state), 0);
        check("t6_cen", 32'(rom_cen), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_quiet", 32'(src_valid), 0);
        end
        sink_branch_en     = 1'b1;
        sink_branch_target = 16'h0100;
        sink_start         = 1'b1;
        tick();
        sink_branch_en = 1'b0;
        sink_start     = 1'b0;
        check("t7_state", 32'(dbg_state), 1);
        check("t7_addr", 32'(rom_address), 32'(16'h0100));
        tick();
        check("t7_pc", 32'(src_pc), 32'(16'h0100));
        check("t7_instr", 32'(src_instr), 32'(mem[16'h0100]));

        // PC wrap on the second instance
        do_reset();
        sink_start2 = 1'b1;
        tick();
        sink_start2 = 1'b0;
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            check("t5_valid", 32'(src_valid2), 1);
            check("t5_pc", 32'(src_pc2), 32'(e));
            check("t5_instr", 32'(src_instr2), 32'(mem[e]));
        end

        // randomized backpressure and branches
        do_reset();
        src_ready = 1'b1;
        start_pulse();
        hs_before = hs_count;
        for (int i = 0; i < 3000; i++) begin
            src_ready          = ($urandom_range(0, 3) != 0);
            sink_branch_en     = ($urandom_range(0, 15) == 0);
            sink_branch_target = 16'($urandom_range(0, 65535));
            tick();
        end
        sink_branch_en = 1'b0;
        src_ready      = 1'b1;
        tick();
        check("rand_progress", 32'((hs_count - hs_before) > 300), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
